// File: rtl/tap_period_meter.sv
`default_nettype none
// ============================================================================
// Module   : tap_period_meter
// Brief    : Measures tp_i intervals between debounced tap rises and emits a
//            running average over 2**AVG_LOG2 intervals, with timeout abort.
// Revision : 1.0 - initial release
// ============================================================================
module tap_period_meter #(
    parameter longint unsigned PULSE_PER_NS   = 64'd4096,
    parameter longint unsigned TIMEOUT_PER_NS = 64'd2147483648,
    parameter int unsigned     AVG_LOG2       = 2,
    localparam longint unsigned MAX_COUNT     = TIMEOUT_PER_NS / PULSE_PER_NS,
    localparam int              CNT_W         = $clog2(MAX_COUNT) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             tp_i,
    input  logic             btn_i,
    output logic [CNT_W-1:0] period_o,
    output logic             period_valid_o,
    output logic             timeout_o,
    output logic             counting_o
);

    localparam int D     = 2 ** AVG_LOG2;
    localparam int SUM_W = CNT_W + AVG_LOG2;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_COUNT);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_COUNT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic               btn_q, btn_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               first_q, first_d;
    logic [CNT_W-1:0]   hist_q [D];
    logic [CNT_W-1:0]   hist_d [D];
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic               upd_q, upd_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic               valid_q, valid_d;
    logic               timeout_q, timeout_d;
    logic               counting_q, counting_d;
    logic               rise;

    assign rise = btn_i & ~btn_q;

    always_comb begin
        state_d   = state_q;
        btn_d     = btn_i;
        cnt_d     = cnt_q;
        first_d   = first_q;
        hist_d    = hist_q;
        sum_d     = sum_q;
        upd_d     = 1'b0;
        timeout_d = 1'b0;
        // Second pipeline stage: publish the average computed on the rise cycle.
        valid_d   = upd_q;
        period_d  = upd_q ? CNT_W'(sum_q >> AVG_LOG2) : period_q;

        unique case (state_q)
            S_IDLE: begin
                if (rise) begin
                    state_d = S_COUNT;
                    cnt_d   = '0;
                    first_d = 1'b1;
                end
            end
            S_COUNT: begin
                if (rise) begin
                    // A tp_i in the rise cycle is dropped; rise also beats timeout.
                    cnt_d = '0;
                    upd_d = 1'b1;
                    if (first_q) begin
                        for (int k = 0; k < D; k++) hist_d[k] = cnt_q;
                        sum_d   = SUM_W'(cnt_q) << AVG_LOG2;
                        first_d = 1'b0;
                    end else begin
                        hist_d[0] = cnt_q;
                        for (int k = 1; k < D; k++) hist_d[k] = hist_q[k-1];
                        sum_d = sum_q - SUM_W'(hist_q[D-1]) + SUM_W'(cnt_q);
                    end
                end else if (tp_i) begin
                    if (cnt_q == MAX_CNT) begin
                        state_d   = S_IDLE;
                        timeout_d = 1'b1;
                        first_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        counting_d = (state_d == S_COUNT);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            btn_q      <= 1'b0;
            cnt_q      <= '0;
            first_q    <= 1'b1;
            for (int k = 0; k < D; k++) hist_q[k] <= '0;
            sum_q      <= '0;
            upd_q      <= 1'b0;
            period_q   <= '0;
            valid_q    <= 1'b0;
            timeout_q  <= 1'b0;
            counting_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            btn_q      <= btn_d;
            cnt_q      <= cnt_d;
            first_q    <= first_d;
            hist_q     <= hist_d;
            sum_q      <= sum_d;
            upd_q      <= upd_d;
            period_q   <= period_d;
            valid_q    <= valid_d;
            timeout_q  <= timeout_d;
            counting_q <= counting_d;
        end
    end

    assign period_o       = period_q;
    assign period_valid_o = valid_q;
    assign timeout_o      = timeout_q;
    assign counting_o     = counting_q;

endmodule
`default_nettype wire

// File: tb/tb_tap_period_meter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tap_period_meter
// Brief    : Self-checking bench: instance A (MAX_COUNT=64), B (MAX_COUNT=1024),
//            checked each cycle against an interval/average model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tap_period_meter;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        btn_a = 1'b0;
    logic        btn_b = 1'b0;
    logic        tp_a;
    logic        tp_b;
    bit          tp_slow_a = 1'b0;
    int          cyc = 0;

    logic [6:0]  per_a;
    logic        val_a, to_a, cnt_a;
    logic [10:0] per_b;
    logic        val_b, to_b, cnt_b;

    int n_checks = 0;
    int n_fail   = 0;
    int obs_a[$];
    int obs_b[$];
    int to_cnt_a = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign tp_a = tp_slow_a ? (cyc[1:0] == 2'd0) : 1'b1;
    assign tp_b = 1'b1;

    tap_period_meter #(
        .PULSE_PER_NS   (64'd4096),
        .TIMEOUT_PER_NS (64'd64 * 64'd4096),
        .AVG_LOG2       (2)
    ) u_a (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .tp_i           (tp_a),
        .btn_i          (btn_a),
        .period_o       (per_a),
        .period_valid_o (val_a),
        .timeout_o      (to_a),
        .counting_o     (cnt_a)
    );

    tap_period_meter #(
        .PULSE_PER_NS   (64'd4096),
        .TIMEOUT_PER_NS (64'd1024 * 64'd4096),
        .AVG_LOG2       (2)
    ) u_b (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .tp_i           (tp_b),
        .btn_i          (btn_b),
        .period_o       (per_b),
        .period_valid_o (val_b),
        .timeout_o      (to_b),
        .counting_o     (cnt_b)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int MAXC [2] = '{64, 1024};
    int m_cnt [2];
    int m_hist [2][4];
    int m_pendv [2];
    int m_period [2];
    bit m_counting [2];
    bit m_first [2];
    bit m_prev [2];
    bit m_pend [2];
    bit m_valid [2];
    bit m_to [2];

    always @(posedge clk or negedge rst_n) begin
        bit b [2];
        bit t [2];
        bit rise;
        int iv;
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_cnt[i] = 0; m_pendv[i] = 0; m_period[i] = 0;
                m_counting[i] = 0; m_first[i] = 1; m_prev[i] = 0;
                m_pend[i] = 0; m_valid[i] = 0; m_to[i] = 0;
                for (int k = 0; k < 4; k++) m_hist[i][k] = 0;
            end
        end else begin
            b[0] = btn_a; b[1] = btn_b;
            t[0] = tp_a;  t[1] = tp_b;
            for (int i = 0; i < 2; i++) begin
                rise = b[i] && !m_prev[i];
                m_prev[i] = b[i];
                m_valid[i] = m_pend[i];
                if (m_pend[i]) m_period[i] = m_pendv[i];
                m_pend[i] = 0;
                m_to[i] = 0;
                if (!m_counting[i]) begin
                    if (rise) begin
                        m_counting[i] = 1; m_cnt[i] = 0; m_first[i] = 1;
                    end
                end else if (rise) begin
                    iv = m_cnt[i];
                    if (m_first[i]) begin
                        for (int k = 0; k < 4; k++) m_hist[i][k] = iv;
                        m_first[i] = 0;
                    end else begin
                        for (int k = 3; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
                        m_hist[i][0] = iv;
                    end
                    m_pendv[i] = (m_hist[i][0] + m_hist[i][1] + m_hist[i][2] + m_hist[i][3]) / 4;
                    m_pend[i] = 1;
                    m_cnt[i] = 0;
                end else if (t[i]) begin
                    if (m_cnt[i] == MAXC[i]) begin
                        m_counting[i] = 0; m_to[i] = 1;
                    end else begin
                        m_cnt[i]++;
                    end
                end
            end
        end
    end

    // Per-cycle comparison plus observation logs, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("a_period",   int'(per_a), m_period[0]);
            chk("a_valid",    int'(val_a), int'(m_valid[0]));
            chk("a_timeout",  int'(to_a),  int'(m_to[0]));
            chk("a_counting", int'(cnt_a), int'(m_counting[0]));
            chk("b_period",   int'(per_b), m_period[1]);
            chk("b_valid",    int'(val_b), int'(m_valid[1]));
            chk("b_timeout",  int'(to_b),  int'(m_to[1]));
            chk("b_counting", int'(cnt_b), int'(m_counting[1]));
            if (val_a) obs_a.push_back(int'(per_a));
            if (val_b) obs_b.push_back(int'(per_b));
            if (to_a)  to_cnt_a++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Rise now, then idle for iv cycles: the next tap's interval is iv at 1 tp/cycle.
    task automatic tap(input int inst, input int iv);
        if (inst == 0) btn_a = 1'b1; else btn_b = 1'b1;
        cycle();
        if (inst == 0) btn_a = 1'b0; else btn_b = 1'b0;
        repeat (iv) cycle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
        obs_a.delete();
        obs_b.delete();
        to_cnt_a = 0;
    endtask

    function automatic int qat(input int q[$], input int idx);
        return (idx < q.size()) ? q[idx] : -1;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Preload then running average on B.
        tap(1, 100); tap(1, 100); tap(1, 100); tap(1, 100);
        tap(1, 200); tap(1, 40);  tap(1, 10);
        repeat (5) cycle();
        chk("b_num_valid", obs_b.size(), 6);
        chk("b_preload",   qat(obs_b, 0), 100);
        chk("b_steady",    qat(obs_b, 3), 100);
        chk("b_avg_200",   qat(obs_b, 4), 125);
        chk("b_avg_40",    qat(obs_b, 5), 110);

        // Async reset mid-count on A.
        tap(0, 30); tap(0, 10);
        chk("a_pre_reset_period", qat(obs_a, 0), 30);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_a_period",   int'(per_a), 0);
        chk("rst_a_valid",    int'(val_a), 0);
        chk("rst_a_counting", int'(cnt_a), 0);
        chk("rst_a_timeout",  int'(to_a),  0);
        chk("rst_b_period",   int'(per_b), 0);
        chk("rst_b_counting", int'(cnt_b), 0);
        cycle();
        rst_n = 1'b1;
        obs_a.delete();
        obs_b.delete();
        to_cnt_a = 0;
        tap(0, 20);
        chk("a_first_tap_no_valid", obs_a.size(), 0);
        chk("a_counting_after_tap", int'(cnt_a), 1);

        // Timeout, then recovery.
        for (int w = 0; w < 200 && to_cnt_a == 0; w++) cycle();
        chk("a_timeout_seen", to_cnt_a, 1);
        repeat (3) cycle();
        chk("a_timeout_once", to_cnt_a, 1);
        chk("a_idle_after_timeout", int'(cnt_a), 0);
        tap(0, 50); tap(0, 5);
        chk("a_after_timeout_num", obs_a.size(), 1);
        chk("a_after_timeout_val", qat(obs_a, 0), 50);

        // Slow tp: rise coincident with tp at counter 9.
        do_reset();
        tp_slow_a = 1'b1;
        while (cyc[1:0] != 2'd0) cycle();
        tap(0, 39); tap(0, 3);
        repeat (3) cycle();
        chk("a_slow_num", obs_a.size(), 1);
        chk("a_slow_val", qat(obs_a, 0), 9);

        // Rise coincident with the timeout condition.
        do_reset();
        tp_slow_a = 1'b0;
        tap(0, 64); tap(0, 3);
        repeat (5) cycle();
        chk("a_edge_num", obs_a.size(), 1);
        chk("a_edge_val", qat(obs_a, 0), 64);
        chk("a_edge_no_timeout", to_cnt_a, 0);
        repeat (80) cycle();
        chk("a_edge_later_timeout", to_cnt_a, 1);
        chk("a_period_held", int'(per_a), 64);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
